// File: rtl/mem_port_arbiter_pkg.sv
// Shared types and helpers for the single-port RAM arbiter.
// Arbitration mode, master-count limit and one-hot index decode.
package mem_arb_pkg;

  typedef enum logic {
    ARB_FIXED = 1'b0,
    ARB_RR    = 1'b1
  } arb_mode_e;

  localparam int MAX_MASTERS = 8;
  localparam int MAX_IDX_W   = 3;

  // OR-reduction decode; the input is expected to be one-hot or zero.
  function automatic logic [MAX_IDX_W-1:0] onehot_to_idx(input logic [MAX_MASTERS-1:0] oh);
    logic [MAX_IDX_W-1:0] idx;
    idx = {MAX_IDX_W{1'b0}};
    for (int i = 0; i < MAX_MASTERS; i++) begin
      if (oh[i]) begin
        idx = idx | MAX_IDX_W'(i);
      end else begin
        idx = idx;
      end
    end
    return idx;
  endfunction

endpackage

// File: rtl/mem_port_arbiter_arb_pick.sv
// Combinational winner selection: fixed priority from index 0, or a
// round-robin search starting at ptr_i and wrapping modulo N_MASTERS.
module arb_pick
  import mem_arb_pkg::*;
#(
  parameter int N_MASTERS = 3,
  parameter int IDX_W     = (N_MASTERS > 1) ? $clog2(N_MASTERS) : 1
) (
  input  logic [N_MASTERS-1:0] req_i,
  input  logic [IDX_W-1:0]     ptr_i,
  input  arb_mode_e            mode_i,
  output logic [N_MASTERS-1:0] gnt_o,
  output logic [IDX_W-1:0]     idx_o
);

  logic                   found_s;
  logic [IDX_W-1:0]       cand_s;
  logic [MAX_MASTERS-1:0] oh_ext_s;
  int                     start_s;
  int                     sum_s;

  // Scan from the start position and grant the first requester found.
  always_comb begin
    gnt_o    = {N_MASTERS{1'b0}};
    found_s  = 1'b0;
    cand_s   = {IDX_W{1'b0}};
    sum_s    = 32'sd0;
    oh_ext_s = {MAX_MASTERS{1'b0}};
    if (mode_i == ARB_RR) begin
      start_s = int'(ptr_i);
    end else begin
      start_s = 32'sd0;
    end
    for (int off = 0; off < N_MASTERS; off++) begin
      sum_s = start_s + off;
      if (sum_s >= N_MASTERS) begin
        sum_s = sum_s - N_MASTERS;
      end else begin
        sum_s = sum_s;
      end
      cand_s = IDX_W'(sum_s);
      if (!found_s && req_i[cand_s]) begin
        gnt_o[cand_s] = 1'b1;
        found_s       = 1'b1;
      end else begin
        found_s = found_s;
      end
    end
    oh_ext_s[N_MASTERS-1:0] = gnt_o;
    idx_o = IDX_W'(onehot_to_idx(oh_ext_s));
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// N-master arbiter for one single-port RAM: registered address/data/wren,
// round-robin pointer, and a read-return pipeline routing mem_q back to its master.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int        N_MASTERS = 3,
  parameter int        ADDR_W    = 8,
  parameter int        DATA_W    = 8,
  parameter arb_mode_e MODE      = ARB_FIXED,
  parameter int        RD_LAT    = 1
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [N_MASTERS-1:0]          req,
  input  logic [N_MASTERS-1:0]          wren_in,
  input  logic [N_MASTERS*ADDR_W-1:0]   addr_in,
  input  logic [N_MASTERS*DATA_W-1:0]   wdata_in,
  output logic [N_MASTERS-1:0]          gnt,
  output logic [ADDR_W-1:0]             mem_addr,
  output logic [DATA_W-1:0]             mem_data,
  output logic                          mem_wren,
  input  logic [DATA_W-1:0]             mem_q,
  output logic [DATA_W-1:0]             rdata,
  output logic [N_MASTERS-1:0]          rvalid
);

  localparam int IDX_W = (N_MASTERS > 1) ? $clog2(N_MASTERS) : 1;

  logic [N_MASTERS-1:0] pick_gnt_s;
  logic [IDX_W-1:0]     win_idx_s;
  logic                 accept_s;
  logic                 rd_accept_s;

  logic [IDX_W-1:0]     ptr_q, ptr_d;
  logic [ADDR_W-1:0]    mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0]    mem_data_q, mem_data_d;
  logic                 mem_wren_q, mem_wren_d;
  logic [N_MASTERS-1:0] rvalid_q, rvalid_d;

  // Return pipeline; rvalid_q is its final stage, giving RD_LAT+1 stages in total.
  logic                 vld_q  [RD_LAT];
  logic [IDX_W-1:0]     ridx_q [RD_LAT];

  arb_pick #(
    .N_MASTERS (N_MASTERS),
    .IDX_W     (IDX_W)
  ) u_pick (
    .req_i  (req),
    .ptr_i  (ptr_q),
    .mode_i (MODE),
    .gnt_o  (pick_gnt_s),
    .idx_o  (win_idx_s)
  );

  assign gnt         = pick_gnt_s & {N_MASTERS{rst_n}};
  assign accept_s    = |gnt;
  assign rd_accept_s = accept_s & ~wren_in[win_idx_s];

  // Next-state for RAM port registers, RR pointer and read-return strobe.
  always_comb begin
    ptr_d      = ptr_q;
    mem_addr_d = mem_addr_q;
    mem_data_d = mem_data_q;
    mem_wren_d = 1'b0;
    rvalid_d   = {N_MASTERS{1'b0}};
    if (accept_s) begin
      mem_addr_d = addr_in[int'(win_idx_s)*ADDR_W +: ADDR_W];
      mem_data_d = wdata_in[int'(win_idx_s)*DATA_W +: DATA_W];
      mem_wren_d = wren_in[win_idx_s];
      if (win_idx_s == IDX_W'(N_MASTERS - 1)) begin
        ptr_d = {IDX_W{1'b0}};
      end else begin
        ptr_d = win_idx_s + IDX_W'(1'b1);
      end
    end else begin
      ptr_d = ptr_q;
    end
    if (vld_q[RD_LAT-1]) begin
      rvalid_d[ridx_q[RD_LAT-1]] = 1'b1;
    end else begin
      rvalid_d = {N_MASTERS{1'b0}};
    end
  end

  // Port and pointer registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_q      <= {IDX_W{1'b0}};
      mem_addr_q <= {ADDR_W{1'b0}};
      mem_data_q <= {DATA_W{1'b0}};
      mem_wren_q <= 1'b0;
      rvalid_q   <= {N_MASTERS{1'b0}};
    end else begin
      ptr_q      <= ptr_d;
      mem_addr_q <= mem_addr_d;
      mem_data_q <= mem_data_d;
      mem_wren_q <= mem_wren_d;
      rvalid_q   <= rvalid_d;
    end
  end

  // Shift {valid, index} of accepted reads toward the return strobe.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int s = 0; s < RD_LAT; s++) begin
        vld_q[s]  <= 1'b0;
        ridx_q[s] <= {IDX_W{1'b0}};
      end
    end else begin
      vld_q[0]  <= rd_accept_s;
      ridx_q[0] <= win_idx_s;
      for (int s = 1; s < RD_LAT; s++) begin
        vld_q[s]  <= vld_q[s-1];
        ridx_q[s] <= ridx_q[s-1];
      end
    end
  end

  assign mem_addr = mem_addr_q;
  assign mem_data = mem_data_q;
  assign mem_wren = mem_wren_q;
  assign rvalid   = rvalid_q;
  assign rdata    = mem_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: one fixed-priority and one round-robin
// instance share stimulus; each sees a RAM model returning registered addr ^ 8'hFF.
module tb_mem_port_arbiter;
  import mem_arb_pkg::*;

  localparam int N  = 3;
  localparam int AW = 8;
  localparam int DW = 8;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic [N-1:0]    req;
  logic [N-1:0]    wren_in;
  logic [N*AW-1:0] addr_in;
  logic [N*DW-1:0] wdata_in;

  logic [N-1:0]    gnt_fx, gnt_rr;
  logic [AW-1:0]   mem_addr_fx, mem_addr_rr;
  logic [DW-1:0]   mem_data_fx, mem_data_rr;
  logic            mem_wren_fx, mem_wren_rr;
  logic [DW-1:0]   q_fx = 8'h00;
  logic [DW-1:0]   q_rr = 8'h00;
  logic [DW-1:0]   rdata_fx, rdata_rr;
  logic [N-1:0]    rvalid_fx, rvalid_rr;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  always @(posedge clk) begin
    q_fx <= mem_addr_fx ^ 8'hFF;
    q_rr <= mem_addr_rr ^ 8'hFF;
  end

  mem_port_arbiter #(.N_MASTERS(N), .ADDR_W(AW), .DATA_W(DW), .MODE(ARB_FIXED), .RD_LAT(1)) dut_fx (
    .clk(clk), .rst_n(rst_n), .req(req), .wren_in(wren_in), .addr_in(addr_in),
    .wdata_in(wdata_in), .gnt(gnt_fx), .mem_addr(mem_addr_fx), .mem_data(mem_data_fx),
    .mem_wren(mem_wren_fx), .mem_q(q_fx), .rdata(rdata_fx), .rvalid(rvalid_fx)
  );

  mem_port_arbiter #(.N_MASTERS(N), .ADDR_W(AW), .DATA_W(DW), .MODE(ARB_RR), .RD_LAT(1)) dut_rr (
    .clk(clk), .rst_n(rst_n), .req(req), .wren_in(wren_in), .addr_in(addr_in),
    .wdata_in(wdata_in), .gnt(gnt_rr), .mem_addr(mem_addr_rr), .mem_data(mem_data_rr),
    .mem_wren(mem_wren_rr), .mem_q(q_rr), .rdata(rdata_rr), .rvalid(rvalid_rr)
  );

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %0h, expected %0h", tag, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  logic [N-1:0] rr_seq [6];

  initial begin
    rr_seq[0] = 3'b001; rr_seq[1] = 3'b010; rr_seq[2] = 3'b100;
    rr_seq[3] = 3'b001; rr_seq[4] = 3'b010; rr_seq[5] = 3'b100;
    req      = 3'b111;
    wren_in  = 3'b000;
    addr_in  = 24'h000000;
    wdata_in = 24'h000000;

    // Reset held with all masters requesting
    #2;
    check_eq("rst_gnt_rr", 32'(gnt_rr), 32'h0);
    check_eq("rst_gnt_fx", 32'(gnt_fx), 32'h0);
    check_eq("rst_wren", 32'(mem_wren_rr), 32'h0);
    check_eq("rst_addr", 32'(mem_addr_rr), 32'h0);
    check_eq("rst_rvalid", 32'(rvalid_rr), 32'h0);
    step();
    step();
    rst_n = 1'b1;
    #1;
    check_eq("rr_first_gnt", 32'(gnt_rr), 32'h1);
    req = 3'b000;
    #1;
    check_eq("idle_gnt_rr", 32'(gnt_rr), 32'h0);
    check_eq("idle_gnt_fx", 32'(gnt_fx), 32'h0);
    step();

    // Fixed priority: master 1 starves master 2
    req = 3'b110;
    for (int i = 0; i < 4; i++) begin
      #1;
      check_eq("fx_hold_110", 32'(gnt_fx), 32'h2);
      step();
    end
    req = 3'b100;
    #1;
    check_eq("fx_drop_req1", 32'(gnt_fx), 32'h4);
    step();
    req = 3'b000;
    step();
    step();

    // Round robin, pointer at 0 here
    req = 3'b111;
    for (int i = 0; i < 6; i++) begin
      #1;
      check_eq("rr_rotate", 32'(gnt_rr), 32'(rr_seq[i]));
      step();
    end
    req = 3'b001;
    step();
    req = 3'b101;
    #1;
    check_eq("rr_101_first", 32'(gnt_rr), 32'h4);
    step();
    #1;
    check_eq("rr_101_second", 32'(gnt_rr), 32'h1);
    step();
    req = 3'b000;
    step();
    step();

    // Master 0 write, pointer at 1
    req = 3'b001;
    wren_in = 3'b001;
    addr_in[0 +: 8] = 8'h10;
    wdata_in[0 +: 8] = 8'hAB;
    #1;
    check_eq("wr_gnt", 32'(gnt_rr), 32'h1);
    step();
    req = 3'b000;
    wren_in = 3'b000;
    check_eq("wr_addr", 32'(mem_addr_rr), 32'h10);
    check_eq("wr_data", 32'(mem_data_rr), 32'hAB);
    check_eq("wr_wren", 32'(mem_wren_rr), 32'h1);
    check_eq("wr_rvalid_t1", 32'(rvalid_rr), 32'h0);
    step();
    check_eq("wr_wren_idle", 32'(mem_wren_rr), 32'h0);
    check_eq("wr_addr_hold", 32'(mem_addr_rr), 32'h10);
    check_eq("wr_rvalid_t2", 32'(rvalid_rr), 32'h0);
    step();
    check_eq("wr_rvalid_t3", 32'(rvalid_rr), 32'h0);

    // Back-to-back reads: master 2 then master 1
    req = 3'b100;
    addr_in[16 +: 8] = 8'h05;
    #1;
    check_eq("rd2_gnt", 32'(gnt_rr), 32'h4);
    step();
    req = 3'b010;
    addr_in[8 +: 8] = 8'h06;
    #1;
    check_eq("rd1_gnt", 32'(gnt_rr), 32'h2);
    step();
    req = 3'b000;
    check_eq("rd2_rvalid", 32'(rvalid_rr), 32'h4);
    check_eq("rd2_rdata", 32'(rdata_rr), 32'hFA);
    check_eq("rd2_rvalid_fx", 32'(rvalid_fx), 32'h4);
    step();
    check_eq("rd1_rvalid", 32'(rvalid_rr), 32'h2);
    check_eq("rd1_rdata", 32'(rdata_rr), 32'hF9);
    step();
    check_eq("rd_rvalid_done", 32'(rvalid_rr), 32'h0);

    // Reset while a master 1 read is in flight (pointer would become 2)
    req = 3'b010;
    addr_in[8 +: 8] = 8'h33;
    #1;
    check_eq("rst_rd_gnt", 32'(gnt_rr), 32'h2);
    step();
    req = 3'b000;
    rst_n = 1'b0;
    #2;
    rst_n = 1'b1;
    step();
    check_eq("midrst_rvalid_t2", 32'(rvalid_rr), 32'h0);
    check_eq("midrst_addr", 32'(mem_addr_rr), 32'h0);
    step();
    check_eq("midrst_rvalid_t3", 32'(rvalid_rr), 32'h0);
    step();
    check_eq("midrst_rvalid_t4", 32'(rvalid_rr), 32'h0);
    req = 3'b111;
    #1;
    check_eq("midrst_ptr0", 32'(gnt_rr), 32'h1);
    req = 3'b000;
    step();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- N-master arbiter for one single-port on-chip RAM (the s_memory/working-memory port used by the init, shuffle and decrypt phases).
- Each phase FSM gets its own req/gnt port, and the arbiter drives the shared RAM address, data and wren.
- Supports fixed-priority or round-robin selection.
- Outputs are registered, idle cycles never write, and read data returns to the master that issued the read.

Parameters:
- N_MASTERS, 3, number of requesting masters (2..8).
- ADDR_W, 8, RAM address width.
- DATA_W, 8, RAM data width.
- MODE, ARB_FIXED, arbitration mode: ARB_FIXED (lowest index wins) or ARB_RR (round-robin).
- RD_LAT, 1, RAM read latency in cycles from a registered mem_addr to valid mem_q (1..3).

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- req  in  N_MASTERS  per-master access request
- wren_in  in  N_MASTERS  per-master write enable (1 = write, 0 = read)
- addr_in  in  N_MASTERS*ADDR_W  packed per-master address; master i occupies [i*ADDR_W +: ADDR_W]
- wdata_in  in  N_MASTERS*DATA_W  packed per-master write data
- gnt  out  N_MASTERS  one-hot accept, combinational, same cycle as req
- mem_addr  out  ADDR_W  registered RAM address
- mem_data  out  DATA_W  registered RAM write data
- mem_wren  out  1  registered RAM write enable
- mem_q  in  DATA_W  RAM read data
- rdata  out  DATA_W  read data to masters (mem_q passed through)
- rvalid  out  N_MASTERS  one-hot read-return strobe

Behaviour:
- Reset (rst_n low, asynchronous): mem_addr=0, mem_data=0, mem_wren=0, rvalid=0, RR pointer=0, read-return pipeline cleared. gnt=0 while rst_n is low.
- Handshake:
  - A master raises req[i] with wren_in/addr_in/wdata_in stable.
  - The transfer is accepted on the rising edge where req[i]&gnt[i]=1.
  - The master must update or drop req on that same edge. A held req means a new access.
- gnt: at most one bit set. Zero when req=0. Never set for a master whose req is low.
- ARB_FIXED: lowest set index of req wins. Starvation of higher indices is allowed.
- ARB_RR:
  - Search starts at the pointer and wraps modulo N_MASTERS.
  - On acceptance by master k, the pointer becomes (k+1) mod N_MASTERS.
  - Pointer is unchanged when idle.
- Accepted access in cycle t: in cycle t+1, mem_addr/mem_data/mem_wren carry that master's values. Throughput is one access per cycle.
- Idle cycle (no grant):
  - mem_wren=0 on the next cycle.
  - mem_addr and mem_data hold their last values.
  - A write is never repeated.
- Read return:
  - A read accepted in cycle t asserts rvalid[k] for exactly one cycle, in cycle t+1+RD_LAT.
  - rdata is valid in that cycle.
  - Writes produce no rvalid.
  - Back-to-back reads return in order, one per cycle.
- Grant-index pipeline: RD_LAT+1 stages of {valid, index}. Cleared asynchronously by reset; a reset mid-flight drops pending returns.
- Simultaneous events: read accept and an earlier read's return in the same cycle are independent. A new grant never blocks a return.
- Width rules: no arithmetic on data. Index width is $clog2(N_MASTERS), minimum 1.

Decomposition:
- Package mem_arb_pkg:
  - typedef enum arb_mode_e {ARB_FIXED, ARB_RR}
  - function onehot_to_idx
  - constant MAX_MASTERS=8
- Sub-module arb_pick: combinational. Inputs req, ptr, mode. Outputs one-hot gnt and winner index. Unit-testable on its own.
- Top contains the RR pointer register, the output registers and the return pipeline.

Test Plan (N_MASTERS=3, ADDR_W=DATA_W=8, RD_LAT=1; RAM model q = registered addr XOR 8'hFF):
- Reset: rst_n=0 with req=3'b111 -> gnt=0, mem_wren=0, mem_addr=0, rvalid=0. Release, then ARB_RR first gnt=3'b001.
- ARB_FIXED, req=3'b110 held 4 cycles -> gnt=3'b010 every cycle, gnt[2] never set. Drop req[1] -> gnt=3'b100 the same cycle.
- ARB_RR, req=3'b111 held 6 cycles -> gnt sequence 001,010,100,001,010,100. With req=3'b101 from pointer=1 -> gnt=100 then 001.
- Write: master0 wren=1 addr=8'h10 data=8'hAB accepted cycle t, no req afterwards -> cycle t+1 mem_addr=8'h10, mem_data=8'hAB, mem_wren=1. Cycle t+2 mem_wren=0, mem_addr still 8'h10. No rvalid.
- Reads: master2 reads 8'h05 at t, master1 reads 8'h06 at t+1 -> rvalid=3'b100 with rdata=8'hFA at t+2, then rvalid=3'b010 with rdata=8'hF9 at t+3.
- Reset mid-flight: master1 read accepted at t, rst_n pulsed low during t+1 -> rvalid stays 0 through t+4. RR pointer=0 after release.
